// File: rtl/uc_pkg.sv
// Shared types and decode helpers for the uc_multi control unit.
// The interrupt path is enabled with the UC_IRQ_EN macro.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TRAP  = 2'd2,
        ST_IRQ   = 2'd3
    } state_t;

    localparam logic [5:0] OP_J    = 6'b110000;
    localparam logic [5:0] OP_JZ   = 6'b110001;
    localparam logic [5:0] OP_JNZ  = 6'b110010;
    localparam logic [5:0] OP_RETI = 6'b111111;

    localparam logic [2:0] ALU_IDLE = 3'b000;

    function automatic logic is_alu(input logic [5:0] op);
        return (op[5] == 1'b0);
    endfunction

    function automatic logic is_ldi(input logic [5:0] op);
        return (op[5:4] == 2'b10);
    endfunction

    function automatic logic is_call(input logic [5:0] op);
        return (op[5:2] == 4'b1110);
    endfunction

    function automatic logic is_ret(input logic [5:0] op);
        return (op[5:2] == 4'b1111);
    endfunction

endpackage

// File: rtl/uc_multi_stack_depth_ctr.sv
// Up/down occupancy counter for the return stack with full/empty flags.
// Simultaneous inc and dec leave the count unchanged.
module stack_depth_ctr #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] TOP  = W'(MAX);

    // Occupancy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + ONE;
        end else if (dec && !inc) begin
            count <= count - ONE;
        end else begin
            count <= count;
        end
    end

    assign full  = (count == TOP);
    assign empty = (count == '0);

endmodule

// File: rtl/uc_multi.sv
// Multicycle FETCH/EXEC control unit with return-stack depth tracking and traps.
// Optional interrupt entry/RETI support is enabled by defining UC_IRQ_EN.
module uc_multi
    import uc_pkg::*;
#(
    parameter  int STACK_DEPTH = 16,
    localparam int CNT_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             imem_valid,
`ifdef UC_IRQ_EN
    input  logic             irq,
    output logic             s_irq,
`endif
    output logic             ir_en,
    output logic             pc_en,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op_alu,
    output logic             push,
    output logic             pop,
    output logic             s_stack,
    output logic             stack_err,
    output logic [CNT_W-1:0] depth
);

    state_t state_r;
    state_t next_state_s;
    logic   full_s;
    logic   empty_s;
    logic   set_err_s;
`ifdef UC_IRQ_EN
    logic   ie_r;
    logic   set_ie_s;
    logic   clr_ie_s;
`endif

    stack_depth_ctr #(
        .MAX (STACK_DEPTH),
        .W   (CNT_W)
    ) u_depth (
        .clk   (clk),
        .rst   (reset),
        .inc   (push),
        .dec   (pop),
        .count (depth),
        .full  (full_s),
        .empty (empty_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sticky trap flag; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_err <= 1'b0;
        end else if (set_err_s) begin
            stack_err <= 1'b1;
        end else begin
            stack_err <= stack_err;
        end
    end

`ifdef UC_IRQ_EN
    // Interrupt enable: cleared on entry, restored by RETI
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_r <= 1'b1;
        end else if (clr_ie_s) begin
            ie_r <= 1'b0;
        end else if (set_ie_s) begin
            ie_r <= 1'b1;
        end else begin
            ie_r <= ie_r;
        end
    end
`endif

    // Next state and Moore strobes from state plus the held opcode/z
    always_comb begin
        next_state_s = state_r;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        s_inc        = 1'b1;
        s_inm        = 1'b0;
        we3          = 1'b0;
        wez          = 1'b0;
        op_alu       = ALU_IDLE;
        push         = 1'b0;
        pop          = 1'b0;
        s_stack      = 1'b0;
        set_err_s    = 1'b0;
`ifdef UC_IRQ_EN
        s_irq        = 1'b0;
        set_ie_s     = 1'b0;
        clr_ie_s     = 1'b0;
`endif
        case (state_r)
            ST_FETCH: begin
`ifdef UC_IRQ_EN
                if (irq && ie_r) begin
                    next_state_s = ST_IRQ;
                end else if (imem_valid) begin
                    ir_en        = 1'b1;
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
`else
                if (imem_valid) begin
                    ir_en        = 1'b1;
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
`endif
            end
            ST_EXEC: begin
                next_state_s = ST_FETCH;
                pc_en        = 1'b1;
                if (is_alu(opcode)) begin
                    op_alu = opcode[4:2];
                    we3    = 1'b1;
                    wez    = 1'b1;
                end else if (is_ldi(opcode)) begin
                    we3   = 1'b1;
                    s_inm = 1'b1;
                end else if (opcode == OP_J) begin
                    s_inc = 1'b0;
                end else if (opcode == OP_JZ) begin
                    s_inc = ~z;
                end else if (opcode == OP_JNZ) begin
                    s_inc = z;
                end else if (is_call(opcode)) begin
                    // A full stack suppresses the push and the PC write
                    if (full_s) begin
                        pc_en        = 1'b0;
                        set_err_s    = 1'b1;
                        next_state_s = ST_TRAP;
                    end else begin
                        push    = 1'b1;
                        s_stack = 1'b1;
                        s_inc   = 1'b0;
                    end
                end else if (is_ret(opcode)) begin
                    if (empty_s) begin
                        pc_en        = 1'b0;
                        set_err_s    = 1'b1;
                        next_state_s = ST_TRAP;
                    end else begin
                        pop     = 1'b1;
                        s_stack = 1'b1;
`ifdef UC_IRQ_EN
                        set_ie_s = (opcode == OP_RETI);
`endif
                    end
                end else begin
                    s_inc = 1'b1;
                end
            end
            ST_TRAP: begin
                next_state_s = ST_TRAP;
            end
`ifdef UC_IRQ_EN
            ST_IRQ: begin
                next_state_s = ST_FETCH;
                clr_ie_s     = 1'b1;
                if (full_s) begin
                    set_err_s    = 1'b1;
                    next_state_s = ST_TRAP;
                end else begin
                    push    = 1'b1;
                    s_stack = 1'b1;
                    s_irq   = 1'b1;
                    pc_en   = 1'b1;
                    s_inc   = 1'b0;
                end
            end
`endif
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_uc_multi.sv
// Self-checking bench for uc_multi (STACK_DEPTH=4); IRQ scenario compiled only with UC_IRQ_EN.
module tb_uc_multi;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          z;
    logic          imem_valid;
    logic          ir_en, pc_en, s_inc, s_inm, we3, wez, push, pop, s_stack, stack_err;
    logic [2:0]    op_alu;
    logic [CW-1:0] depth;
`ifdef UC_IRQ_EN
    logic          irq;
    logic          s_irq;
`endif

    int checks   = 0;
    int failures = 0;

    uc_multi #(.STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .z          (z),
        .imem_valid (imem_valid),
`ifdef UC_IRQ_EN
        .irq        (irq),
        .s_irq      (s_irq),
`endif
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .s_inc      (s_inc),
        .s_inm      (s_inm),
        .we3        (we3),
        .wez        (wez),
        .op_alu     (op_alu),
        .push       (push),
        .pop        (pop),
        .s_stack    (s_stack),
        .stack_err  (stack_err),
        .depth      (depth)
    );

    always #5 clk = ~clk;

    logic [7:0] strobes;
    assign strobes = {ir_en, pc_en, we3, wez, s_inm, push, pop, s_stack};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_valid = 1'b0;
        opcode     = 6'd0;
        z          = 1'b0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Drive one instruction through FETCH; returns in EXEC and counts FETCH cycles seen
    task automatic fetch_exec(input logic [5:0] op, input logic zz, input int nwait, output int fcyc);
        opcode = op;
        z      = zz;
        fcyc   = 0;
        for (int i = 0; i < nwait; i++) begin
            imem_valid = 1'b0;
            #1;
            if (ir_en === 1'b0 && pc_en === 1'b0) fcyc++;
            step();
        end
        imem_valid = 1'b1;
        #1;
        if (ir_en === 1'b1) fcyc++;
        step();
        imem_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int f;
        do_reset();
        checks++;
        if (strobes !== 8'd0 || op_alu !== 3'd0 || s_inc !== 1'b1 || depth !== '0 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: strobes=%b op_alu=%b s_inc=%b depth=%0d err=%b, want 0/0/1/0/0",
                     strobes, op_alu, s_inc, depth, stack_err);
        end
        fetch_exec(6'b111000, 1'b0, 0, f);
        step();
        fetch_exec(6'b000100, 1'b0, 0, f);
        checks++;
        if (we3 !== 1'b1 || depth !== CW'(1)) begin
            failures++;
            $display("FAIL reset_pre_exec: we3=%b depth=%0d, want 1 and 1", we3, depth);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (strobes !== 8'd0 || op_alu !== 3'd0 || depth !== '0) begin
            failures++;
            $display("FAIL reset_mid_exec: strobes=%b op_alu=%b depth=%0d, want all 0", strobes, op_alu, depth);
        end
        step();
        reset      = 1'b0;
        imem_valid = 1'b1;
        #1;
        checks++;
        if (ir_en !== 1'b1 || pc_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_fetch: ir_en=%b pc_en=%b, want 1 0", ir_en, pc_en);
        end
        imem_valid = 1'b0;
    endtask

    task automatic test_fetch_wait();
        int f;
        do_reset();
        fetch_exec(6'b001000, 1'b0, 3, f);
        checks++;
        if (f !== 4) begin
            failures++;
            $display("FAIL fetch_wait_cycles: got %0d, want 4", f);
        end
        checks++;
        if (op_alu !== 3'b010 || we3 !== 1'b1 || wez !== 1'b1 || s_inm !== 1'b0 || pc_en !== 1'b1 || s_inc !== 1'b1) begin
            failures++;
            $display("FAIL alu_exec: op_alu=%b we3=%b wez=%b s_inm=%b pc_en=%b s_inc=%b, want 010 1 1 0 1 1",
                     op_alu, we3, wez, s_inm, pc_en, s_inc);
        end
        step();
        checks++;
        if (pc_en !== 1'b0 || we3 !== 1'b0) begin
            failures++;
            $display("FAIL pc_en_one_cycle: pc_en=%b we3=%b, want 0 0", pc_en, we3);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [5] = '{6'b110001, 6'b110001, 6'b110010, 6'b110010, 6'b110000};
        logic       zs  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       want;
        int f;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 4)      want = 1'b0;
            else if (i < 2)  want = ~zs[i];
            else             want = zs[i];
            fetch_exec(ops[i], zs[i], 0, f);
            checks++;
            if (s_inc !== want || we3 !== 1'b0 || push !== 1'b0 || pc_en !== 1'b1) begin
                failures++;
                $display("FAIL branch_%0d: op=%b z=%b s_inc=%b we3=%b push=%b pc_en=%b, want s_inc=%b",
                         i, ops[i], zs[i], s_inc, we3, push, pc_en, want);
            end
            step();
        end
    endtask

    task automatic test_random();
        int mdepth = 0;
        int f, w, opi;
        logic [5:0] op;
        logic zz, call, ret;
        logic [10:0] exp_v, got_v;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            opi  = int'($urandom_range(0, 63));
            zz   = 1'($urandom_range(0, 1));
            w    = int'($urandom_range(0, 2));
            call = (opi >= 56 && opi < 60);
            ret  = (opi >= 60);
            if ((call && mdepth == DEPTH) || (ret && mdepth == 0)) begin
                opi  = 51;
                call = 1'b0;
                ret  = 1'b0;
            end
            op = 6'(opi);
            exp_v[10] = 1'b1;
            exp_v[9]  = (opi < 48);
            exp_v[8]  = (opi < 32);
            exp_v[7]  = (opi >= 32 && opi < 48);
            if (opi == 48 || call)  exp_v[6] = 1'b0;
            else if (opi == 49)     exp_v[6] = ~zz;
            else if (opi == 50)     exp_v[6] = zz;
            else                    exp_v[6] = 1'b1;
            exp_v[5]   = call;
            exp_v[4]   = ret;
            exp_v[3]   = call | ret;
            exp_v[2:0] = (opi < 32) ? 3'((opi / 4) % 8) : 3'd0;
            fetch_exec(op, zz, w, f);
            got_v = {pc_en, we3, wez, s_inm, s_inc, push, pop, s_stack, op_alu};
            checks++;
            if (got_v !== exp_v || f !== w + 1) begin
                failures++;
                $display("FAIL random_%0d: op=%b z=%b got=%b fetch=%0d, want %b fetch=%0d",
                         n, op, zz, got_v, f, exp_v, w + 1);
            end
            step();
            if (call) mdepth++;
            if (ret)  mdepth--;
            checks++;
            if (depth !== CW'(mdepth)) begin
                failures++;
                $display("FAIL random_depth_%0d: got %0d, want %0d", n, depth, mdepth);
            end
        end
    endtask

    task automatic test_overflow();
        int f;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            fetch_exec(6'b111000, 1'b0, 0, f);
            checks++;
            if (push !== 1'b1 || s_stack !== 1'b1 || pc_en !== 1'b1 || s_inc !== 1'b0) begin
                failures++;
                $display("FAIL call_%0d: push=%b s_stack=%b pc_en=%b s_inc=%b, want 1 1 1 0",
                         i, push, s_stack, pc_en, s_inc);
            end
            step();
        end
        checks++;
        if (depth !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL depth_full: got %0d, want %0d", depth, DEPTH);
        end
        fetch_exec(6'b111000, 1'b0, 0, f);
        checks++;
        if (push !== 1'b0 || pc_en !== 1'b0 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL overflow_exec: push=%b pc_en=%b err=%b, want 0 0 0", push, pc_en, stack_err);
        end
        step();
        checks++;
        if (stack_err !== 1'b1 || depth !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL overflow_err: err=%b depth=%0d, want 1 %0d", stack_err, depth, DEPTH);
        end
        imem_valid = 1'b1;
        opcode     = 6'b000100;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (strobes !== 8'd0 || stack_err !== 1'b1) begin
                failures++;
                $display("FAIL trap_hold_%0d: strobes=%b err=%b, want 0 1", i, strobes, stack_err);
            end
            step();
        end
        imem_valid = 1'b0;
    endtask

    task automatic test_underflow();
        int f;
        do_reset();
        fetch_exec(6'b111100, 1'b0, 0, f);
        checks++;
        if (pop !== 1'b0 || pc_en !== 1'b0) begin
            failures++;
            $display("FAIL underflow_exec: pop=%b pc_en=%b, want 0 0", pop, pc_en);
        end
        step();
        checks++;
        if (stack_err !== 1'b1 || depth !== '0) begin
            failures++;
            $display("FAIL underflow_err: err=%b depth=%0d, want 1 0", stack_err, depth);
        end
        imem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ir_en !== 1'b0 || pc_en !== 1'b0) begin
                failures++;
                $display("FAIL underflow_trap_%0d: ir_en=%b pc_en=%b, want 0 0", i, ir_en, pc_en);
            end
            step();
        end
        imem_valid = 1'b0;
    endtask

`ifdef UC_IRQ_EN
    task automatic test_irq();
        int f;
        irq = 1'b0;
        do_reset();
        irq        = 1'b1;
        imem_valid = 1'b1;
        #1;
        checks++;
        if (ir_en !== 1'b0) begin
            failures++;
            $display("FAIL irq_priority: ir_en=%b, want 0", ir_en);
        end
        step();
        imem_valid = 1'b0;
        #1;
        checks++;
        if (s_irq !== 1'b1 || push !== 1'b1 || s_stack !== 1'b1 || pc_en !== 1'b1) begin
            failures++;
            $display("FAIL irq_cycle: s_irq=%b push=%b s_stack=%b pc_en=%b, want 1 1 1 1", s_irq, push, s_stack, pc_en);
        end
        step();
        fetch_exec(6'b111111, 1'b0, 0, f);
        checks++;
        if (f !== 1 || pop !== 1'b1 || s_irq !== 1'b0 || depth !== CW'(1)) begin
            failures++;
            $display("FAIL reti_exec: fetch=%0d pop=%b s_irq=%b depth=%0d, want 1 1 0 1", f, pop, s_irq, depth);
        end
        step();
        imem_valid = 1'b1;
        #1;
        checks++;
        if (depth !== '0 || ir_en !== 1'b0) begin
            failures++;
            $display("FAIL reti_ie: depth=%0d ir_en=%b, want 0 0", depth, ir_en);
        end
        irq        = 1'b0;
        imem_valid = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef UC_IRQ_EN
        irq = 1'b0;
`endif
        test_reset();
        test_fetch_wait();
        test_branch();
        test_random();
        test_overflow();
        test_underflow();
`ifdef UC_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uc_multi.md
# uc_multi

Multicycle control unit for the second-generation CPU. It replaces the single-cycle decoder with a registered FETCH/EXEC state machine and adds an instruction-memory ready handshake. It tracks subroutine-stack depth with a parametrised counter and traps on stack overflow or underflow. It sits between the instruction register (opcode, `z` flag) and the datapath: PC mux, register bank, ALU and return stack.

## Interface
Parameters:
- `STACK_DEPTH`, 16: number of return-stack entries; power of two, 2..256.
- `CNT_W`, $clog2(STACK_DEPTH)+1: depth counter width; derived, not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  6  opcode field from the instruction register; stable from the cycle after `ir_en` onward.
- `z`  in  1  registered zero flag from the datapath.
- `imem_valid`  in  1  instruction memory word valid this cycle.
- `irq`  in  1  level interrupt request; present only with `UC_IRQ_EN`.
- `ir_en`  out  1  load the instruction register.
- `pc_en`  out  1  write the PC.
- `s_inc`  out  1  PC mux select: 1 = PC+1, 0 = jump target.
- `s_inm`  out  1  register write-data select: 1 = immediate, 0 = ALU.
- `we3`  out  1  register bank write enable.
- `wez`  out  1  zero flag write enable.
- `op_alu`  out  3  ALU operation.
- `push`  out  1  return stack push strobe.
- `pop`  out  1  return stack pop strobe.
- `s_stack`  out  1  PC mux select: PC from stack (pop) or PC routed to stack (push).
- `s_irq`  out  1  PC mux select: interrupt vector; present only with `UC_IRQ_EN`.
- `stack_err`  out  1  sticky stack overflow/underflow flag.
- `depth`  out  CNT_W  current stack occupancy.

## Operation
- States: FETCH, EXEC, TRAP, plus IRQ with `UC_IRQ_EN`.
- Reset value: state FETCH, `depth`=0, `stack_err`=0, all strobes 0, `op_alu`=0, `s_inc`=1.
- Every output has an explicit default in every state. No output holds a stale value.
- FETCH:
  - `ir_en`=`imem_valid`.
  - Moves to EXEC on `imem_valid`; otherwise stays in FETCH.
- EXEC: `pc_en`=1 for exactly one cycle, then FETCH. Opcode decode:
  - `0xxxxx` ALU: `op_alu`=opcode[4:2], `we3`=1, `wez`=1, `s_inm`=0, `s_inc`=1.
  - `10xxxx` load immediate: `we3`=1, `s_inm`=1, `s_inc`=1.
  - `110000` J: `s_inc`=0.
  - `110001` JZ: `s_inc`=~z.
  - `110010` JNZ: `s_inc`=z.
  - `1110xx` CALL: `push`=1, `s_stack`=1, `s_inc`=0, `depth`+1.
  - `1111xx` RET: `pop`=1, `s_stack`=1, `depth`-1.
  - Anything else is a NOP: `s_inc`=1, no writes.
- Overflow: CALL with `depth`==STACK_DEPTH.
  - `push`=0, `pc_en`=0.
  - `stack_err` set; next state TRAP.
- Underflow: RET with `depth`==0.
  - `pop`=0, `pc_en`=0.
  - `stack_err` set; next state TRAP.
- TRAP: all strobes 0, `ir_en`=0. Leaves only on `reset`.
- `depth` saturates logically because of the checks above; it never wraps.

## Timing
- Minimum 2 cycles per instruction: FETCH (with `imem_valid`=1), then EXEC.
- Each extra cycle with `imem_valid`=0 adds one FETCH cycle.
- Strobes are Moore outputs of the state plus the registered `opcode`/`z`. They are valid the whole EXEC cycle; the datapath samples them on the EXEC→FETCH edge.
- `depth` and `stack_err` update on the same edge as the push/pop.
- `reset` asserted mid-EXEC clears all outputs immediately (asynchronous), with no partial write.

## Configuration
- `UC_IRQ_EN` defined:
  - In FETCH, `irq`=1 with the interrupt-enable bit `ie`=1 takes priority over `imem_valid` and moves to IRQ.
  - IRQ lasts one cycle: `push`=1, `s_stack`=1, `s_irq`=1, `pc_en`=1, `depth`+1, `ie` cleared.
  - Overflow rules apply as for CALL.
  - Opcode `111111` becomes RETI: RET behaviour plus `ie` set.
  - `ie` resets to 1.
- `UC_IRQ_EN` undefined:
  - No `irq`/`s_irq` ports and no IRQ state.
  - `111111` is a plain RET.

## Structure
- Package `uc_pkg`: state enum, opcode pattern constants, ALU op encodings.
- One sub-module, `stack_depth_ctr`: parametrised up/down counter with `full`/`empty` outputs, asynchronous reset, and inc/dec ignored when both are asserted. Instantiated once.

## Test plan
- Reset mid-EXEC of `000100` → all strobes 0 immediately; `depth`=0; FETCH after release.
- Opcode `001000`, `imem_valid` held 0 for 3 cycles then 1 → 4 FETCH cycles, then EXEC with `op_alu`=3'b010, `we3`=`wez`=1.
- JZ `110001` with `z`=1 → `s_inc`=0; with `z`=0 → `s_inc`=1. JNZ `110010` gives the inverse.
- STACK_DEPTH=4: four CALLs (`111000`) → `depth`=4; fifth CALL → `push`=0, `pc_en`=0, `stack_err`=1, TRAP held for 10 cycles.
- RET (`111100`) at `depth`=0 → `pop`=0, `stack_err`=1, TRAP.
- `UC_IRQ_EN`: `irq`=1 in FETCH with `imem_valid`=1 → IRQ cycle (`s_irq`=1, `push`=1), second `irq` ignored, RETI (`111111`) → `pop`=1, `ie`=1, `depth` back to 0.
